dma_timing_ctrl: RTL and testbench
==================================

# dma_timing_ctrl

Transfer timing and control state machine of the 8237A-style DMA controller; it sits directly downstream of the priority encoder. It takes the winning channel request, runs the HRQ/HLDA bus handshake, and asserts the channel's logical DACK. It sequences the SI/S0/S1/S2/S3/S4 transfer states, drives the bus command strobes, and pulses the address/count update. Termination is on terminal count or external EOP.

## Interface
Parameters:
- `CH_W`, default 2, width of the channel index.

Ports:
- `CLK`  in  1  system clock; every register updates on the rising edge.
- `RESET`  in  1  reset, synchronous and active-high.
- `reqValid`  in  1  priority stage has a valid, unmasked, winning DREQ.
- `reqCh`  in  CH_W  index of the winning channel.
- `HLDA`  in  1  hold acknowledge from the CPU.
- `READY`  in  1  memory/IO ready; low inserts wait states in S3.
- `xferType`  in  2  mode register bits [3:2]: 00 verify, 01 write (IO to mem), 10 read (mem to IO), 11 illegal (treated as verify).
- `xferMode`  in  2  mode register bits [7:6]: 00 demand, 01 single, 10 block, 11 cascade (treated as single).
- `tcIn`  in  1  current word count is 0 (this transfer is the last one).
- `upperCarry`  in  1  address bits [15:8] change on this update.
- `eopInN`  in  1  external EOP, active-low.
- `HRQ`  out  1  hold request to the CPU.
- `AEN`  out  1  address enable.
- `ADSTB`  out  1  upper-address strobe.
- `validDACK`  out  1  logical DACK to the priority stage.
- `dackCh`  out  CH_W  serviced channel, latched at grant.
- `MEMR_N`, `MEMW_N`, `IOR_N`, `IOW_N`  out  1 each  command strobes, active-low.
- `eopOutN`  out  1  internal EOP, active-low.
- `updStrobe`  out  1  one-cycle pulse that tells the address/count block to step.
- `tcSet`  out  1  one-cycle pulse that sets the serviced channel's TC status bit.

## Operation
- State register `st`: SI, S0, S1, S2, S3, S4.
- Reset values: `st` is SI; `HRQ`, `AEN`, `ADSTB`, `validDACK`, `updStrobe` and `tcSet` are 0; `dackCh` is 0; all `_N` outputs are 1.
- **SI**:
  - If `reqValid`, latch `reqCh` into `dackCh`, set `HRQ`, and go to S0.
- **S0**:
  - Hold `HRQ`.
  - If `HLDA`, go to S1.
  - If `reqValid` drops before `HLDA` arrives, clear `HRQ` and go to SI.
- **S1**: `AEN`=1 and `ADSTB`=1 for this cycle only; go to S2.
- **S2**:
  - `validDACK`=1.
  - Assert the read strobe: IOR_N for write transfers, MEMR_N for read transfers, none for verify.
  - Go to S3.
- **S3**:
  - Keep the read strobe asserted.
  - Assert the write strobe: MEMW_N for write transfers, IOW_N for read transfers.
  - If `READY`=0, stay in S3.
  - Otherwise go to S4.
- **S4**:
  - Deassert all strobes.
  - Pulse `updStrobe`.
  - If `tcIn`, pulse `tcSet` and drive `eopOutN`=0.
  - Termination (`tcIn`, or `eopInN` sampled low in S2, S3 or S4): go to SI and clear `HRQ`, `AEN` and `validDACK`.
  - Single mode: go to SI and clear `HRQ`, so HRQ is low for at least one cycle before re-request.
  - Demand mode: continue only if `reqValid` is high and `reqCh` equals `dackCh`; otherwise go to SI.
  - Block mode: continue.
  - Continue: go to S1 if `upperCarry`, else go to S2.
- `AEN` stays 1 from S1 through S4 for the whole service; `validDACK` stays 1 from S2 through S4.
- HLDA loss: if `HLDA` is low in any of S1–S4, the next edge goes to SI with every output at its reset value. No `updStrobe` is issued for the interrupted transfer.
- `RESET` during service: same forced state as HLDA loss, regardless of `st`.

## Timing
- All outputs are registered and are functions of the state entered on the edge.
- `reqValid` sampled high at edge n gives `HRQ`=1 after edge n.
- `HLDA` high at edge m gives S1 (AEN, ADSTB) after edge m.
- Minimum transfer with READY=1:
  - first transfer takes 4 cycles (S1, S2, S3, S4);
  - subsequent transfers take 3 cycles (S2, S3, S4);
  - a transfer with `upperCarry` takes 4 cycles.
- Each low READY sample in S3 adds exactly one cycle.
- `eopOutN` is low for exactly the S4 cycle of the TC transfer.
- If `eopInN` and `tcIn` are both active, one `tcSet` pulse is issued and the service ends once.

## Test plan
- Single-mode write, ch2, HLDA returned 2 cycles after HRQ:
  - states SI, S0, S0, S1, S2, S3, S4, SI;
  - `dackCh`=2;
  - IOR_N low during S2–S3, MEMW_N low during S3;
  - one `updStrobe`;
  - HRQ low for at least one cycle afterwards.
- Block-mode read of 3 words, `tcIn` on the third:
  - S1, S2, S3, S4, S2, S3, S4, S2, S3, S4;
  - `tcSet` and `eopOutN` low in the last S4;
  - HRQ drops.
- READY held low for 2 cycles in S3: S3 lasts 3 cycles and the strobes hold.
- Demand mode, `reqValid` drops during the second transfer: the controller exits after that S4 with 2 `updStrobe` pulses.
- `eopInN` pulsed low in S3 of a block transfer: termination after S4, with no `tcSet`.
- HLDA dropped in S2, and separately RESET asserted in S3: the next cycle is SI, all strobes are 1, HRQ=0, and there is no `updStrobe`.

Source files
------------

// File: rtl/dma_timing_ctrl.sv
// dma_timing_ctrl: 8237A-style transfer sequencer.
// Runs HRQ/HLDA, walks SI..S4, drives strobes and count-update pulses.
module dma_timing_ctrl #(
  parameter int CH_W = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            reqValid,
  input  logic [CH_W-1:0] reqCh,
  input  logic            HLDA,
  input  logic            READY,
  input  logic [1:0]      xferType,
  input  logic [1:0]      xferMode,
  input  logic            tcIn,
  input  logic            upperCarry,
  input  logic            eopInN,
  output logic            HRQ,
  output logic            AEN,
  output logic            ADSTB,
  output logic            validDACK,
  output logic [CH_W-1:0] dackCh,
  output logic            MEMR_N,
  output logic            MEMW_N,
  output logic            IOR_N,
  output logic            IOW_N,
  output logic            eopOutN,
  output logic            updStrobe,
  output logic            tcSet
);

  typedef enum logic [2:0] {
    SI, S0, S1, S2, S3, S4
  } st_t;

  st_t  st;
  logic eopSeen;

  logic isWrite;
  logic isRead;
  logic single;
  logic demand;
  logic sameReq;
  logic busy;
  logic term;

  assign isWrite = (xferType == 2'b01);
  assign isRead  = (xferType == 2'b10);
  // cascade (11) shares the single-mode exit path
  assign single  = xferMode[0];
  assign demand  = (xferMode == 2'b00);
  assign sameReq = reqValid && (reqCh == dackCh);
  assign busy    = (st == S1) || (st == S2)
                || (st == S3) || (st == S4);
  // tcSet is high exactly in the S4 of the TC word
  assign term    = tcSet || eopSeen || !eopInN;

  always_ff @(posedge CLK) begin
    if (RESET || (busy && !HLDA)) begin
      st        <= SI;
      eopSeen   <= 1'b0;
      HRQ       <= 1'b0;
      AEN       <= 1'b0;
      ADSTB     <= 1'b0;
      validDACK <= 1'b0;
      dackCh    <= '0;
      MEMR_N    <= 1'b1;
      MEMW_N    <= 1'b1;
      IOR_N     <= 1'b1;
      IOW_N     <= 1'b1;
      eopOutN   <= 1'b1;
      updStrobe <= 1'b0;
      tcSet     <= 1'b0;
    end else begin
      ADSTB     <= 1'b0;
      updStrobe <= 1'b0;
      tcSet     <= 1'b0;
      eopOutN   <= 1'b1;
      unique case (st)
        SI: begin
          if (reqValid) begin
            dackCh <= reqCh;
            HRQ    <= 1'b1;
            st     <= S0;
          end
        end
        S0: begin
          if (HLDA) begin
            AEN   <= 1'b1;
            ADSTB <= 1'b1;
            st    <= S1;
          end else if (!reqValid) begin
            HRQ <= 1'b0;
            st  <= SI;
          end
        end
        S1: begin
          validDACK <= 1'b1;
          MEMR_N    <= !isRead;
          IOR_N     <= !isWrite;
          st        <= S2;
        end
        S2: begin
          eopSeen <= eopSeen || !eopInN;
          MEMW_N  <= !isWrite;
          IOW_N   <= !isRead;
          st      <= S3;
        end
        S3: begin
          eopSeen <= eopSeen || !eopInN;
          if (READY) begin
            MEMR_N    <= 1'b1;
            MEMW_N    <= 1'b1;
            IOR_N     <= 1'b1;
            IOW_N     <= 1'b1;
            updStrobe <= 1'b1;
            tcSet     <= tcIn;
            eopOutN   <= !tcIn;
            st        <= S4;
          end
        end
        S4: begin
          eopSeen <= 1'b0;
          if (term || single || (demand && !sameReq)) begin
            HRQ       <= 1'b0;
            AEN       <= 1'b0;
            validDACK <= 1'b0;
            st        <= SI;
          end else if (upperCarry) begin
            ADSTB <= 1'b1;
            st    <= S1;
          end else begin
            MEMR_N <= !isRead;
            IOR_N  <= !isWrite;
            st     <= S2;
          end
        end
        default: st <= SI;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// tb_dma_timing_ctrl: directed and randomized services of the
// DMA timing controller checked against a per-word behavioural model.
module tb_dma_timing_ctrl;
  localparam int CH_W = 2;
  localparam int IDLE = 9;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            reqValid;
  logic [CH_W-1:0] reqCh;
  logic            HLDA;
  logic            READY;
  logic [1:0]      xferType;
  logic [1:0]      xferMode;
  logic            tcIn;
  logic            upperCarry;
  logic            eopInN;
  logic            HRQ;
  logic            AEN;
  logic            ADSTB;
  logic            validDACK;
  logic [CH_W-1:0] dackCh;
  logic            MEMR_N;
  logic            MEMW_N;
  logic            IOR_N;
  logic            IOW_N;
  logic            eopOutN;
  logic            updStrobe;
  logic            tcSet;

  int nvec = 0;
  int nerr = 0;

  logic [10:0] obs;
  assign obs = {HRQ, AEN, ADSTB, validDACK, MEMR_N, MEMW_N,
                IOR_N, IOW_N, eopOutN, updStrobe, tcSet};

  always #5 CLK = ~CLK;

  dma_timing_ctrl #(.CH_W(CH_W)) dut (
    .CLK(CLK), .RESET(RESET), .reqValid(reqValid), .reqCh(reqCh),
    .HLDA(HLDA), .READY(READY), .xferType(xferType),
    .xferMode(xferMode), .tcIn(tcIn), .upperCarry(upperCarry),
    .eopInN(eopInN), .HRQ(HRQ), .AEN(AEN), .ADSTB(ADSTB),
    .validDACK(validDACK), .dackCh(dackCh), .MEMR_N(MEMR_N),
    .MEMW_N(MEMW_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
    .eopOutN(eopOutN), .updStrobe(updStrobe), .tcSet(tcSet)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Expected outputs while the controller sits in phase ph.
  function automatic logic [10:0] expv(input int ph, input int typ,
                                       input bit first, input bit tc);
    bit act, rd, wr, wt, rt;
    act = (ph >= 0) && (ph <= 4);
    rd  = (ph == 2) || (ph == 3);
    wr  = (ph == 3);
    wt  = (typ == 1);
    rt  = (typ == 2);
    expv = {act,
            act && ph >= 1,
            ph == 1,
            (ph >= 2 && act) || (ph == 1 && !first),
            !(rd && rt), !(wr && wt), !(rd && wt), !(wr && rt),
            !(ph == 4 && tc),
            ph == 4,
            ph == 4 && tc};
  endfunction

  task automatic expect_ph(input int ph, input int typ, input bit first,
                           input bit tc, input int ch, input string tag);
    chk($sformatf("%s ph%0d", tag, ph), 32'(obs),
        32'(expv(ph, typ, first, tc)));
    if (ph != IDLE)
      chk($sformatf("%s dackCh", tag), 32'(dackCh), 32'(ch));
  endtask

  // One service: grant, then words until TC, EOP, single exit or demand drop.
  task automatic service(input int ch, input int typ, input int mode,
                         input int hd, input int tcw, input int eopw,
                         input int dropw, input int wfix,
                         input bit carry_en);
    bit sgl, dmd, done, cr;
    int w, nwait;
    string tg;
    sgl = (mode == 1) || (mode == 3);
    dmd = (mode == 0);
    tg  = $sformatf("svc ch%0d t%0d m%0d", ch, typ, mode);
    reqValid = 1'b1; reqCh = CH_W'(ch);
    xferType = 2'(typ); xferMode = 2'(mode);
    HLDA = 1'b0; READY = 1'b1; tcIn = 1'b0;
    eopInN = 1'b1; upperCarry = 1'b0;
    tick(); expect_ph(0, typ, 1, 0, ch, tg);
    for (int d = 0; d < hd; d++) begin
      tick(); expect_ph(0, typ, 1, 0, ch, tg);
    end
    HLDA = 1'b1;
    tick(); expect_ph(1, typ, 1, 0, ch, tg);
    tick(); expect_ph(2, typ, 0, 0, ch, tg);
    w = 1;
    done = 0;
    while (!done) begin
      tcIn = (w == tcw);
      tick();
      expect_ph(3, typ, 0, 0, ch, tg);
      eopInN = (w != eopw);
      nwait = (wfix >= 0) ? wfix : int'($urandom_range(0, 2));
      for (int k = 0; k < nwait; k++) begin
        READY = 1'b0;
        tick(); expect_ph(3, typ, 0, 0, ch, tg);
        eopInN = 1'b1;
      end
      READY = 1'b1;
      tick(); expect_ph(4, typ, 0, w == tcw, ch, tg);
      eopInN = 1'b1;
      cr = carry_en ? 1'($urandom_range(0, 1)) : 1'b0;
      upperCarry = cr;
      reqValid = !(dmd && w == dropw);
      done = (w == tcw) || (w == eopw) || sgl || (dmd && w == dropw);
      tick();
      if (done) begin
        expect_ph(IDLE, typ, 0, 0, ch, tg);
      end else if (cr) begin
        expect_ph(1, typ, 0, 0, ch, tg);
        upperCarry = 1'b0;
        tick(); expect_ph(2, typ, 0, 0, ch, tg);
      end else begin
        expect_ph(2, typ, 0, 0, ch, tg);
      end
      w++;
    end
    reqValid = 1'b0; HLDA = 1'b0; tcIn = 1'b0; upperCarry = 1'b0;
    tick(); expect_ph(IDLE, typ, 0, 0, ch, {tg, " gap"});
  endtask

  initial begin
    int m, t, tw, ew, dw;
    RESET = 1'b1; reqValid = 1'b0; reqCh = '0; HLDA = 1'b0;
    READY = 1'b1; xferType = 2'b00; xferMode = 2'b00; tcIn = 1'b0;
    upperCarry = 1'b0; eopInN = 1'b1;
    tick(); tick();
    expect_ph(IDLE, 0, 0, 0, 0, "reset");
    chk("reset dackCh", 32'(dackCh), 32'd0);
    RESET = 1'b0;

    service(2, 1, 1, 1, 0, 0, 0, 0, 0);
    service(1, 2, 2, 0, 3, 0, 0, 0, 0);
    service(0, 1, 1, 0, 0, 0, 0, 2, 0);
    service(3, 2, 0, 0, 0, 0, 2, 0, 0);
    service(1, 1, 2, 1, 0, 2, 0, 0, 0);
    service(2, 2, 2, 0, 2, 2, 0, 1, 1);
    service(3, 0, 3, 2, 0, 0, 0, 1, 0);

    // Request withdrawn before HLDA
    reqValid = 1'b1; reqCh = 2'd3; xferType = 2'd1; xferMode = 2'd1;
    tick(); expect_ph(0, 1, 1, 0, 3, "withdraw");
    reqValid = 1'b0;
    tick(); expect_ph(IDLE, 1, 1, 0, 3, "withdraw");

    // HLDA lost in S2
    reqValid = 1'b1; reqCh = 2'd1;
    tick(); expect_ph(0, 1, 1, 0, 1, "hlda loss");
    HLDA = 1'b1;
    tick(); expect_ph(1, 1, 1, 0, 1, "hlda loss");
    tick(); expect_ph(2, 1, 0, 0, 1, "hlda loss");
    HLDA = 1'b0;
    tick(); expect_ph(IDLE, 1, 0, 0, 1, "hlda loss");
    chk("hlda loss dackCh", 32'(dackCh), 32'd0);
    reqValid = 1'b0;
    tick(); expect_ph(IDLE, 1, 0, 0, 1, "hlda loss after");

    // RESET in S3
    reqValid = 1'b1; reqCh = 2'd2; xferType = 2'd2;
    tick(); expect_ph(0, 2, 1, 0, 2, "reset s3");
    HLDA = 1'b1;
    tick(); expect_ph(1, 2, 1, 0, 2, "reset s3");
    tick(); expect_ph(2, 2, 0, 0, 2, "reset s3");
    tick(); expect_ph(3, 2, 0, 0, 2, "reset s3");
    RESET = 1'b1;
    tick(); expect_ph(IDLE, 2, 0, 0, 2, "reset s3");
    chk("reset s3 dackCh", 32'(dackCh), 32'd0);
    RESET = 1'b0; reqValid = 1'b0; HLDA = 1'b0;
    tick(); expect_ph(IDLE, 2, 0, 0, 2, "reset s3 after");

    for (int i = 0; i < 30; i++) begin
      m  = int'($urandom_range(0, 3));
      t  = int'($urandom_range(0, 3));
      tw = int'($urandom_range(1, 4));
      ew = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      dw = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
      service(int'($urandom_range(0, 3)), t, m,
              int'($urandom_range(0, 2)), tw, ew, dw, -1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
